// File: rtl/match_turn_ctrl_if.sv
// rtl/match_turn_ctrl_if.sv - turn sequencer bus: pick inputs, deck read port, board state outputs
interface match_turn_ctrl_if #(
  parameter int NUM_CARDS = 36,
  parameter int VAL_W     = 5
);
  logic                 start;
  logic                 select;
  logic [5:0]           cursor;
  logic [5:0]           rd_addr;
  logic [VAL_W-1:0]     card_val;
  logic [5:0]           card1_loc;
  logic [5:0]           card2_loc;
  logic [NUM_CARDS-1:0] revealed;
  logic [NUM_CARDS-1:0] matched;
  logic                 match_pulse;
  logic                 miss_pulse;
  logic [7:0]           attempts;
  logic                 game_over;
  logic [2:0]           state;

  modport slave (
    input  start, select, cursor, card_val,
    output rd_addr, card1_loc, card2_loc, revealed, matched,
           match_pulse, miss_pulse, attempts, game_over, state
  );

  modport master (
    output start, select, cursor, card_val,
    input  rd_addr, card1_loc, card2_loc, revealed, matched,
           match_pulse, miss_pulse, attempts, game_over, state
  );
endinterface

// File: rtl/match_turn_ctrl.sv
// rtl/match_turn_ctrl.sv - memory-match turn sequencer: pick, fetch, compare, reveal, score
// Optional SKIP_REVEAL_EN: a select during SHOW ends the mismatch reveal early.
module match_turn_ctrl #(
  parameter int NUM_CARDS     = 36,
  parameter int REVEAL_CYCLES = 50000000,
  parameter int VAL_W         = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  match_turn_ctrl_if.slave bus
);
  localparam int PAIRS = NUM_CARDS / 2;
  localparam int CNT_W = $clog2(PAIRS + 1);
  localparam int TMR_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT1   = 3'd1,
    FETCH1  = 3'd2,
    WAIT2   = 3'd3,
    FETCH2  = 3'd4,
    COMPARE = 3'd5,
    SHOW    = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t               state_q;
  logic [5:0]           rd_addr_q;
  logic [5:0]           card1_loc_q;
  logic [5:0]           card2_loc_q;
  logic [VAL_W-1:0]     val1_q;
  logic [VAL_W-1:0]     val2_q;
  logic [TMR_W-1:0]     timer_q;
  logic [CNT_W-1:0]     match_cnt_q;
  logic [CNT_W-1:0]     match_cnt_d;
  logic [NUM_CARDS-1:0] matched_q;
  logic [7:0]           attempts_q;
  logic [7:0]           attempts_d;
  logic                 match_pulse_q;
  logic                 miss_pulse_q;

  logic [NUM_CARDS-1:0] card1_oh;
  logic [NUM_CARDS-1:0] card2_oh;
  logic                 cursor_free;
  logic                 pick_ok;

  always_comb begin
    // Out-of-range cursors never index the matched bitmap.
    cursor_free = 1'b0;
    if (int'(bus.cursor) < NUM_CARDS) begin
      cursor_free = ~matched_q[bus.cursor];
    end
    pick_ok = bus.select & cursor_free &
              ((state_q != WAIT2) | (bus.cursor != card1_loc_q));

    match_cnt_d = match_cnt_q + 1'b1;
    attempts_d  = (attempts_q == 8'hFF) ? attempts_q : attempts_q + 8'd1;

    card1_oh = '0;
    card2_oh = '0;
    if ((state_q >= FETCH1) && (state_q <= SHOW)) begin
      card1_oh[card1_loc_q] = 1'b1;
    end
    if ((state_q >= FETCH2) && (state_q <= SHOW)) begin
      card2_oh[card2_loc_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      card1_loc_q   <= '0;
      card2_loc_q   <= '0;
      val1_q        <= '0;
      val2_q        <= '0;
      timer_q       <= '0;
      match_cnt_q   <= '0;
      matched_q     <= '0;
      attempts_q    <= '0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
    end else begin
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      if (bus.start) begin
        matched_q   <= '0;
        match_cnt_q <= '0;
        attempts_q  <= '0;
        timer_q     <= '0;
        state_q     <= WAIT1;
      end else begin
        case (state_q)
          IDLE: ;
          WAIT1: begin
            if (pick_ok) begin
              card1_loc_q <= bus.cursor;
              rd_addr_q   <= bus.cursor;
              state_q     <= FETCH1;
            end
          end
          FETCH1: begin
            val1_q  <= bus.card_val;
            state_q <= WAIT2;
          end
          WAIT2: begin
            if (pick_ok) begin
              card2_loc_q <= bus.cursor;
              rd_addr_q   <= bus.cursor;
              state_q     <= FETCH2;
            end
          end
          FETCH2: begin
            val2_q  <= bus.card_val;
            state_q <= COMPARE;
          end
          COMPARE: begin
            attempts_q <= attempts_d;
            if (val1_q == val2_q) begin
              matched_q     <= matched_q | card1_oh | card2_oh;
              match_cnt_q   <= match_cnt_d;
              match_pulse_q <= 1'b1;
              state_q       <= (match_cnt_d == CNT_W'(PAIRS)) ? DONE : WAIT1;
            end else begin
              timer_q <= TMR_W'(REVEAL_CYCLES - 1);
              state_q <= SHOW;
            end
          end
          SHOW: begin
`ifdef SKIP_REVEAL_EN
            if (bus.select) begin
              timer_q      <= '0;
              miss_pulse_q <= 1'b1;
              state_q      <= WAIT1;
            end else
`endif
            if (timer_q == '0) begin
              miss_pulse_q <= 1'b1;
              state_q      <= WAIT1;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.card1_loc   = card1_loc_q;
  assign bus.card2_loc   = card2_loc_q;
  assign bus.matched     = matched_q;
  assign bus.revealed    = matched_q | card1_oh | card2_oh;
  assign bus.match_pulse = match_pulse_q;
  assign bus.miss_pulse  = miss_pulse_q;
  assign bus.attempts    = attempts_q;
  assign bus.game_over   = (state_q == DONE);
  assign bus.state       = state_q;
endmodule

// File: tb/tb_match_turn_ctrl.sv
// tb/tb_match_turn_ctrl.sv - directed bench with a turn-level reference model of match_turn_ctrl
module tb_match_turn_ctrl;
  localparam int NUM    = 36;
  localparam int REVEAL = 4;
  localparam int VW     = 5;
`ifdef SKIP_REVEAL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  match_turn_ctrl_if #(.NUM_CARDS(NUM), .VAL_W(VW)) bus ();

  match_turn_ctrl #(.NUM_CARDS(NUM), .REVEAL_CYCLES(REVEAL), .VAL_W(VW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Deck: the two halves of pair k live at locations 2k and 2k+1.
  assign bus.card_val = VW'(bus.rd_addr >> 1);

  // Reference model kept at the level of the game rules.
  int             m_st    = 0;
  int             m_c1    = 0;
  int             m_c2    = 0;
  int             m_rd    = 0;
  int             m_att   = 0;
  int             m_cnt   = 0;
  int             m_dwell = 0;
  logic [NUM-1:0] m_mt    = '0;
  bit             m_mp    = 1'b0;
  bit             m_ms    = 1'b0;

  function automatic bit legal(input int loc, input bit second);
    if (!bus.select || loc >= NUM) return 1'b0;
    if (m_mt[loc]) return 1'b0;
    if (second && loc == m_c1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NUM-1:0] exp_rev();
    logic [NUM-1:0] r;
    r = m_mt;
    if (m_st >= 2 && m_st <= 6) r[m_c1] = 1'b1;
    if (m_st >= 4 && m_st <= 6) r[m_c2] = 1'b1;
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 0; m_c1 <= 0; m_c2 <= 0; m_rd <= 0; m_att <= 0;
      m_cnt <= 0; m_dwell <= 0; m_mt <= '0; m_mp <= 1'b0; m_ms <= 1'b0;
    end else begin
      m_mp <= 1'b0;
      m_ms <= 1'b0;
      if (bus.start) begin
        m_mt <= '0; m_cnt <= 0; m_att <= 0; m_dwell <= 0; m_st <= 1;
      end else if (m_st == 1 && legal(int'(bus.cursor), 1'b0)) begin
        m_c1 <= int'(bus.cursor); m_rd <= int'(bus.cursor); m_st <= 2;
      end else if (m_st == 2) begin
        m_st <= 3;
      end else if (m_st == 3 && legal(int'(bus.cursor), 1'b1)) begin
        m_c2 <= int'(bus.cursor); m_rd <= int'(bus.cursor); m_st <= 4;
      end else if (m_st == 4) begin
        m_st <= 5;
      end else if (m_st == 5) begin
        m_att <= (m_att < 255) ? m_att + 1 : 255;
        if (m_c1 / 2 == m_c2 / 2) begin
          m_mt[m_c1] <= 1'b1;
          m_mt[m_c2] <= 1'b1;
          m_cnt      <= m_cnt + 1;
          m_mp       <= 1'b1;
          m_st       <= (m_cnt + 1 == NUM / 2) ? 7 : 1;
        end else begin
          m_dwell <= REVEAL;
          m_st    <= 6;
        end
      end else if (m_st == 6) begin
        if ((SKIP && bus.select) || m_dwell == 1) begin
          m_ms <= 1'b1; m_st <= 1; m_dwell <= 0;
        end else begin
          m_dwell <= m_dwell - 1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    cmp("state",       64'(bus.state),       64'(m_st));
    cmp("rd_addr",     64'(bus.rd_addr),     64'(m_rd));
    cmp("card1_loc",   64'(bus.card1_loc),   64'(m_c1));
    cmp("card2_loc",   64'(bus.card2_loc),   64'(m_c2));
    cmp("matched",     64'(bus.matched),     64'(m_mt));
    cmp("revealed",    64'(bus.revealed),    64'(exp_rev()));
    cmp("match_pulse", 64'(bus.match_pulse), 64'(m_mp));
    cmp("miss_pulse",  64'(bus.miss_pulse),  64'(m_ms));
    cmp("attempts",    64'(bus.attempts),    64'(m_att));
    cmp("game_over",   64'(bus.game_over),   64'(m_st == 7));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic sel(input int loc);
    @(negedge clock);
    bus.cursor = 6'(loc);
    bus.select = 1'b1;
    @(negedge clock);
    bus.select = 1'b0;
  endtask

  task automatic strt();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.select = 1'b0;
    bus.cursor = '0;
    idle(2);
    cmp("lit_reset_state", 64'(bus.state), 64'd0);
    cmp("lit_reset_attempts", 64'(bus.attempts), 64'd0);
    cmp("lit_reset_revealed", 64'(bus.revealed), 64'd0);
    #2 reset_n = 1'b1;

    // select before start is ignored
    sel(0);
    cmp("lit_idle_select", 64'(bus.state), 64'd0);
    strt();
    cmp("lit_start_wait1", 64'(bus.state), 64'd1);

    // first pair matches
    sel(0); sel(1); idle(2);
    cmp("lit_match_pulse", 64'(bus.match_pulse), 64'd1);
    cmp("lit_match_bits", 64'(bus.matched[1:0]), 64'd3);
    cmp("lit_match_attempts", 64'(bus.attempts), 64'd1);
    cmp("lit_match_state", 64'(bus.state), 64'd1);

    // mismatch: revealed for exactly REVEAL cycles
    strt();
    sel(0); sel(2); idle(2);
    cmp("lit_show_state", 64'(bus.state), 64'd6);
    cmp("lit_show_revealed", 64'(bus.revealed), 64'h5);
    idle(3);
    cmp("lit_show_last", 64'(bus.state), 64'd6);
    idle(1);
    cmp("lit_miss_pulse", 64'(bus.miss_pulse), 64'd1);
    cmp("lit_miss_revealed", 64'(bus.revealed), 64'd0);
    cmp("lit_miss_attempts", 64'(bus.attempts), 64'd1);

    // illegal picks
    sel(0); sel(1); idle(2);
    sel(0);
    cmp("lit_matched_pick_state", 64'(bus.state), 64'd1);
    cmp("lit_matched_pick_rd", 64'(bus.rd_addr), 64'd1);
    sel(40);
    cmp("lit_range_pick_state", 64'(bus.state), 64'd1);
    sel(2); idle(1);
    sel(2);
    cmp("lit_same_pick_state", 64'(bus.state), 64'd3);
    cmp("lit_same_pick_rd", 64'(bus.rd_addr), 64'd2);
    sel(1);
    cmp("lit_matched2_state", 64'(bus.state), 64'd3);
    sel(3); idle(2);

    // select during SHOW
    sel(4); sel(6); idle(2);
    sel(8);
    cmp("lit_show_select", 64'(bus.state), SKIP ? 64'd1 : 64'd6);
    if (SKIP) cmp("lit_skip_miss", 64'(bus.miss_pulse), 64'd1);
    idle(3);

    // full game
    strt();
    for (int k = 0; k < NUM / 2; k++) begin
      sel(2 * k); sel(2 * k + 1); idle(2);
    end
    cmp("lit_done_state", 64'(bus.state), 64'd7);
    cmp("lit_done_over", 64'(bus.game_over), 64'd1);
    cmp("lit_done_attempts", 64'(bus.attempts), 64'd18);
    cmp("lit_done_matched", 64'(bus.matched), 64'hF_FFFF_FFFF);
    sel(4);
    cmp("lit_done_select", 64'(bus.state), 64'd7);
    strt();
    cmp("lit_restart_state", 64'(bus.state), 64'd1);
    cmp("lit_restart_matched", 64'(bus.matched), 64'd0);
    cmp("lit_restart_attempts", 64'(bus.attempts), 64'd0);

    // start during SHOW, then start and select together
    sel(0); sel(3); idle(3);
    strt();
    cmp("lit_show_start_state", 64'(bus.state), 64'd1);
    cmp("lit_show_start_att", 64'(bus.attempts), 64'd0);
    cmp("lit_show_start_rev", 64'(bus.revealed), 64'd0);
    @(negedge clock);
    bus.start = 1'b1; bus.select = 1'b1; bus.cursor = 6'd4;
    @(negedge clock);
    bus.start = 1'b0; bus.select = 1'b0;
    cmp("lit_start_prio_state", 64'(bus.state), 64'd1);
    cmp("lit_start_prio_rd", 64'(bus.rd_addr), 64'd3);

    // reset mid-turn
    sel(4); sel(5);
    cmp("lit_fetch2_state", 64'(bus.state), 64'd4);
    #2 reset_n = 1'b0;
    #1;
    cmp("lit_rst_state", 64'(bus.state), 64'd0);
    cmp("lit_rst_card1", 64'(bus.card1_loc), 64'd0);
    cmp("lit_rst_card2", 64'(bus.card2_loc), 64'd0);
    cmp("lit_rst_rd", 64'(bus.rd_addr), 64'd0);
    idle(2);
    #2 reset_n = 1'b1;
    strt();
    sel(8); sel(9); idle(2);
    cmp("lit_after_rst_att", 64'(bus.attempts), 64'd1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/match_turn_ctrl.md
Name: match_turn_ctrl

Overview:
- Turn sequencer for the 6x6 memory-match game.
- Takes synchronized start/select pulses and the cursor location from the arrow-key block, and fetches card values from the deck memory.
- Compares each pair, holds mismatches visible for a fixed reveal time, then flips them back. Tracks matched cards, attempts and game completion.
- Drives card1/card2 locations and the revealed bitmap consumed by the LED grid and VGA draw blocks.

Parameters:
- NUM_CARDS, 36, number of card slots; must be even; cursor values >= NUM_CARDS are invalid.
- REVEAL_CYCLES, 50000000, clock cycles a mismatched pair stays revealed (1 s at 50 MHz); must be >= 1.
- VAL_W, 5, width of a card value.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle synchronized start/restart pulse
- select  in  1  one-cycle synchronized card-select pulse
- cursor  in  6  current cursor location, 0..NUM_CARDS-1
- rd_addr  out  6  deck memory read address
- card_val  in  VAL_W  deck data; valid exactly 1 cycle after rd_addr is driven
- card1_loc  out  6  first selected location
- card2_loc  out  6  second selected location
- revealed  out  NUM_CARDS  face-up bitmap (matched plus current picks)
- matched  out  NUM_CARDS  permanently matched bitmap
- match_pulse  out  1  one cycle high on a pair match
- miss_pulse  out  1  one cycle high when a mismatch flips back
- attempts  out  8  completed pair comparisons, saturating at 255
- game_over  out  1  high while in DONE
- state  out  3  encoded FSM state

Behaviour:
- Reset values: all outputs 0; state IDLE; val1/val2 registers 0; timer 0; match count 0.
- State encoding: IDLE=0, WAIT1=1, FETCH1=2, WAIT2=3, FETCH2=4, COMPARE=5, SHOW=6, DONE=7.
- IDLE: start -> WAIT1. select ignored.
- A pick is legal when all hold: select=1; cursor < NUM_CARDS; matched[cursor]=0; and, in WAIT2 only, cursor != card1_loc. Illegal selects are ignored with no state change.
- WAIT1: on a legal pick, card1_loc <= cursor, rd_addr <= cursor, then FETCH1.
- FETCH1 (1 cycle): val1 <= card_val, then WAIT2.
- WAIT2: on a legal pick, card2_loc <= cursor, rd_addr <= cursor, then FETCH2.
- FETCH2 (1 cycle): val2 <= card_val, then COMPARE.
- COMPARE (1 cycle): attempts++ (saturating).
  - If val1 == val2: set matched at card1_loc and card2_loc, match count++, match_pulse=1. Go to DONE if match count == NUM_CARDS/2, else WAIT1.
  - Else: load timer with REVEAL_CYCLES-1, then SHOW.
- SHOW: timer decrements each cycle. When it reads 0: miss_pulse=1, then WAIT1. Total SHOW dwell is exactly REVEAL_CYCLES cycles. select ignored.
- DONE: game_over=1; only start has effect.
- start in any non-IDLE state (including mid-SHOW): next cycle clears matched, match count, attempts and timer, then WAIT1. start has priority over select in the same cycle.
- revealed = matched | onehot(card1_loc) in states FETCH1..SHOW | onehot(card2_loc) in states FETCH2..SHOW. Combinational from registered state.
- card1_loc/card2_loc keep their last values outside the reveal window.
- Asserting reset_n low at any time returns immediately to reset values, mid-turn included.

Optional Feature:
- Macro SKIP_REVEAL_EN.
- Defined: a select pulse during SHOW ends the reveal. Next cycle is WAIT1 with miss_pulse=1. The select is not used as a first-card pick.
- Undefined: select in SHOW is ignored; SHOW always lasts REVEAL_CYCLES.

Test Plan:
- Test setup: REVEAL_CYCLES=4; deck memory model with value = location/2, so each pair is locations 2k and 2k+1.
- Reset, start, select 0, select 1 -> match_pulse one cycle; matched[1:0]=2'b11; attempts=1; state=WAIT1.
- Select 0, then select 2 -> SHOW for exactly 4 cycles; revealed bits 0 and 2 set during SHOW; miss_pulse; bits clear; attempts=1.
- Select the same card twice, select a matched card, cursor=40 -> each select ignored; state unchanged; rd_addr unchanged.
- Match all 18 pairs in order -> after the last COMPARE, state=7, game_over=1, attempts=18. start -> matched=0, attempts=0, state=1.
- Start during SHOW, and reset_n low during FETCH2 -> restart/reset values as specified. With SKIP_REVEAL_EN defined, select in SHOW exits after 1 cycle with miss_pulse.
